// File: rtl/dm_ctrl_pkg.sv
// Shared types and field positions for the DataMover command sequencer.
// Command offsets marked _OFS are relative to the top of the BTT field.
package dm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_S2MM  = 2'd1,
    ST_MM2S  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned STS_OKAY    = 7;
  localparam int unsigned STS_SLVERR  = 6;
  localparam int unsigned STS_DECERR  = 5;
  localparam int unsigned STS_INTERR  = 4;
  localparam int unsigned STS_TAG_MSB = 3;
  localparam int unsigned STS_TAG_LSB = 0;

  localparam int unsigned ERR_SLV = 0;
  localparam int unsigned ERR_DEC = 1;
  localparam int unsigned ERR_INT = 2;
  localparam int unsigned ERR_TAG = 3;

  localparam int unsigned CMD_TYPE_OFS = 0;
  localparam int unsigned CMD_DSA_OFS  = 1;
  localparam int unsigned CMD_EOF_OFS  = 7;
  localparam int unsigned CMD_DRR_OFS  = 8;
  localparam int unsigned CMD_ADDR_OFS = 9;

  function automatic int unsigned cmd_w(input int unsigned addr_w, input int unsigned btt_w);
    return addr_w + btt_w + 17;
  endfunction

endpackage

// File: rtl/dm_cmd_pack.sv
// Combinational packer for one DataMover command word: INCR burst, EOF set,
// DSA and DRR zero, reserved nibble zero.
module dm_cmd_pack
  import dm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BTT_W  = 23,
  localparam int unsigned CMD_W = cmd_w(ADDR_W, BTT_W)
) (
  input  logic [3:0]        tag_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [BTT_W-1:0]  btt_i,
  output logic [CMD_W-1:0]  cmd_o
);

  // Field placement
  always_comb begin
    cmd_o                                     = '0;
    cmd_o[BTT_W-1:0]                          = btt_i;
    cmd_o[BTT_W+CMD_TYPE_OFS]                 = 1'b1;
    cmd_o[BTT_W+CMD_EOF_OFS]                  = 1'b1;
    cmd_o[BTT_W+CMD_ADDR_OFS +: ADDR_W]       = addr_i;
    cmd_o[BTT_W+CMD_ADDR_OFS+ADDR_W +: 4]     = tag_i;
  end

endmodule

// File: rtl/dm_xfer_ctrl.sv
// Splits a buffer copy into S2MM/MM2S command pairs of at most CHUNK bytes,
// throttles on outstanding S2MM status and collects sticky error flags.
module dm_xfer_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BTT_W   = 23,
  parameter int unsigned LEN_W   = 32,
  parameter int unsigned CHUNK   = 65536,
  parameter int unsigned MAX_OUT = 4,
  localparam int unsigned CMD_W  = cmd_w(ADDR_W, BTT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] saddr,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [LEN_W-1:0]  len,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic [3:0]        err,
  output logic [CMD_W-1:0]  m_axis_s2mm_cmd_tdata,
  output logic              m_axis_s2mm_cmd_tvalid,
  input  logic              m_axis_s2mm_cmd_tready,
  output logic [CMD_W-1:0]  m_axis_mm2s_cmd_tdata,
  output logic              m_axis_mm2s_cmd_tvalid,
  input  logic              m_axis_mm2s_cmd_tready,
  input  logic [7:0]        s_axis_s2mm_sts_tdata,
  input  logic              s_axis_s2mm_sts_tvalid,
  output logic              s_axis_s2mm_sts_tready
);

  localparam logic [LEN_W-1:0] CHUNK_L = LEN_W'(CHUNK);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d, daddr_q, daddr_d;
  logic [LEN_W-1:0]  rem_q, rem_d, cur_len_s;
  logic [3:0]        tag_q, tag_d, exp_tag_q, exp_tag_d;
  logic [3:0]        out_q, out_d, err_q, err_d, new_err_s;
  logic              ready_q, done_q, done_d;
  logic              s2mm_vld_q, mm2s_vld_q;
  logic [CMD_W-1:0]  s2mm_data_q, mm2s_data_q, s2mm_cmd_s, mm2s_cmd_s;
  logic [BTT_W-1:0]  nxt_btt_s;
  logic              s2mm_hs_s, mm2s_hs_s, sts_hs_s, sts_dec_s, start_acc_s;

  assign s_axis_s2mm_sts_tready = ~rst;
  assign s2mm_hs_s   = s2mm_vld_q & m_axis_s2mm_cmd_tready;
  assign mm2s_hs_s   = mm2s_vld_q & m_axis_mm2s_cmd_tready;
  assign sts_hs_s    = s_axis_s2mm_sts_tvalid & s_axis_s2mm_sts_tready;
  assign sts_dec_s   = sts_hs_s && (out_q != 4'd0);
  assign start_acc_s = (state_q == ST_IDLE) && start;
  assign cur_len_s   = (rem_q > CHUNK_L) ? CHUNK_L : rem_q;
  assign nxt_btt_s   = (rem_d > CHUNK_L) ? BTT_W'(CHUNK) : BTT_W'(rem_d);

  // Commands are packed from next-state fields so the registered words track the state
  dm_cmd_pack #(.ADDR_W(ADDR_W), .BTT_W(BTT_W)) u_pack_s2mm (
    .tag_i (tag_d), .addr_i(daddr_d), .btt_i(nxt_btt_s), .cmd_o(s2mm_cmd_s)
  );
  dm_cmd_pack #(.ADDR_W(ADDR_W), .BTT_W(BTT_W)) u_pack_mm2s (
    .tag_i (tag_d), .addr_i(saddr_d), .btt_i(nxt_btt_s), .cmd_o(mm2s_cmd_s)
  );

  // Next-state, error and outstanding-count logic
  always_comb begin
    state_d   = state_q;
    saddr_d   = saddr_q;
    daddr_d   = daddr_q;
    rem_d     = rem_q;
    tag_d     = tag_q;
    exp_tag_d = exp_tag_q;
    done_d    = 1'b0;
    new_err_s = 4'b0000;

    if (sts_hs_s) begin
      new_err_s[ERR_SLV] = s_axis_s2mm_sts_tdata[STS_SLVERR];
      new_err_s[ERR_DEC] = s_axis_s2mm_sts_tdata[STS_DECERR];
      new_err_s[ERR_INT] = s_axis_s2mm_sts_tdata[STS_INTERR];
      // A beat with nothing outstanding is stray and counts as a tag error
      new_err_s[ERR_TAG] = (out_q == 4'd0) ||
                           (s_axis_s2mm_sts_tdata[STS_TAG_MSB:STS_TAG_LSB] != exp_tag_q);
    end else begin
      new_err_s = 4'b0000;
    end

    if (sts_dec_s) begin
      exp_tag_d = exp_tag_q + 4'd1;
    end else begin
      exp_tag_d = exp_tag_q;
    end

    err_d = (start_acc_s ? 4'b0000 : err_q) | new_err_s;
    out_d = out_q + {3'b000, mm2s_hs_s} - {3'b000, sts_dec_s};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          saddr_d   = saddr;
          daddr_d   = daddr;
          rem_d     = len;
          tag_d     = 4'd0;
          exp_tag_d = 4'd0;
          if (len == {LEN_W{1'b0}}) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_S2MM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_S2MM: begin
        // An accepted S2MM command must be paired with its MM2S even on error
        if (s2mm_hs_s) begin
          state_d = ST_MM2S;
        end else if (err_d != 4'b0000) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_S2MM;
        end
      end
      ST_MM2S: begin
        if (mm2s_hs_s) begin
          saddr_d = saddr_q + ADDR_W'(cur_len_s);
          daddr_d = daddr_q + ADDR_W'(cur_len_s);
          rem_d   = rem_q - cur_len_s;
          tag_d   = tag_q + 4'd1;
          if ((rem_d == {LEN_W{1'b0}}) || (err_d != 4'b0000)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_S2MM;
          end
        end else begin
          state_d = ST_MM2S;
        end
      end
      ST_DRAIN: begin
        if (out_d == 4'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      saddr_q     <= '0;
      daddr_q     <= '0;
      rem_q       <= '0;
      tag_q       <= 4'd0;
      exp_tag_q   <= 4'd0;
      out_q       <= 4'd0;
      err_q       <= 4'b0000;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      s2mm_vld_q  <= 1'b0;
      mm2s_vld_q  <= 1'b0;
      s2mm_data_q <= '0;
      mm2s_data_q <= '0;
    end else begin
      state_q     <= state_d;
      saddr_q     <= saddr_d;
      daddr_q     <= daddr_d;
      rem_q       <= rem_d;
      tag_q       <= tag_d;
      exp_tag_q   <= exp_tag_d;
      out_q       <= out_d;
      err_q       <= err_d;
      ready_q     <= (state_d == ST_IDLE);
      done_q      <= done_d;
      s2mm_vld_q  <= (state_d == ST_S2MM) && (out_d < 4'(MAX_OUT));
      mm2s_vld_q  <= (state_d == ST_MM2S);
      s2mm_data_q <= s2mm_cmd_s;
      mm2s_data_q <= mm2s_cmd_s;
    end
  end

  assign ready                  = ready_q;
  assign done                   = done_q;
  assign err                    = err_q;
  assign m_axis_s2mm_cmd_tvalid = s2mm_vld_q;
  assign m_axis_s2mm_cmd_tdata  = s2mm_data_q;
  assign m_axis_mm2s_cmd_tvalid = mm2s_vld_q;
  assign m_axis_mm2s_cmd_tdata  = mm2s_data_q;

endmodule

// File: tb/tb_dm_xfer_ctrl.sv
// Directed bench for dm_xfer_ctrl: expected commands are queued at job start
// and compared on each command handshake.
module tb_dm_xfer_ctrl;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BTT_W   = 23;
  localparam int unsigned LEN_W   = 32;
  localparam int unsigned CHUNK   = 65536;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned CMD_W   = 72;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] saddr = '0, daddr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              start = 1'b0;
  logic              ready, done;
  logic [3:0]        err;
  logic [CMD_W-1:0]  s2mm_tdata, mm2s_tdata;
  logic              s2mm_tvalid, mm2s_tvalid;
  logic              s2mm_tready = 1'b1, mm2s_tready = 1'b1;
  logic [7:0]        sts_tdata = 8'h00;
  logic              sts_tvalid = 1'b0;
  logic              sts_tready;

  int vec = 0, miss = 0;
  int cycle = 0, start_cyc = 0;
  int s2mm_n = 0, mm2s_n = 0, done_n = 0;
  logic             s2_stall = 1'b0, mm_stall = 1'b0;
  logic [CMD_W-1:0] s2_hold = '0, mm_hold = '0;
  logic [CMD_W-1:0] s2mm_q[$], mm2s_q[$];
  int               s2mm_cyc[$];

  always #5 clk = ~clk;

  dm_xfer_ctrl #(
    .ADDR_W(ADDR_W), .BTT_W(BTT_W), .LEN_W(LEN_W), .CHUNK(CHUNK), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .saddr(saddr), .daddr(daddr), .len(len), .start(start),
    .ready(ready), .done(done), .err(err),
    .m_axis_s2mm_cmd_tdata(s2mm_tdata), .m_axis_s2mm_cmd_tvalid(s2mm_tvalid),
    .m_axis_s2mm_cmd_tready(s2mm_tready),
    .m_axis_mm2s_cmd_tdata(mm2s_tdata), .m_axis_mm2s_cmd_tvalid(mm2s_tvalid),
    .m_axis_mm2s_cmd_tready(mm2s_tready),
    .s_axis_s2mm_sts_tdata(sts_tdata), .s_axis_s2mm_sts_tvalid(sts_tvalid),
    .s_axis_s2mm_sts_tready(sts_tready)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [CMD_W-1:0] exp_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                               input logic [22:0] btt);
    return {4'b0000, tag, addr, 1'b0, 1'b1, 6'b000000, 1'b1, btt};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already set; samples, then crosses one rising edge.
  task automatic cyc();
    logic [CMD_W-1:0] e;
    #1;
    if (s2_stall) begin
      check("s2mm_vld_held", s2mm_tvalid, 1'b1);
      check("s2mm_data_held", s2mm_tdata, s2_hold);
    end
    if (mm_stall) begin
      check("mm2s_vld_held", mm2s_tvalid, 1'b1);
      check("mm2s_data_held", mm2s_tdata, mm_hold);
    end
    if (s2mm_tvalid && s2mm_tready) begin
      check("s2mm_expected", s2mm_q.size() != 0, 1'b1);
      if (s2mm_q.size() != 0) begin
        e = s2mm_q.pop_front();
        check("s2mm_cmd", s2mm_tdata, e);
      end
      s2mm_n++;
      s2mm_cyc.push_back(cycle);
    end
    if (mm2s_tvalid && mm2s_tready) begin
      check("mm2s_expected", mm2s_q.size() != 0, 1'b1);
      if (mm2s_q.size() != 0) begin
        e = mm2s_q.pop_front();
        check("mm2s_cmd", mm2s_tdata, e);
      end
      mm2s_n++;
    end
    if (done) done_n++;
    s2_stall = s2mm_tvalid && !s2mm_tready;
    s2_hold  = s2mm_tdata;
    mm_stall = mm2s_tvalid && !mm2s_tready;
    mm_hold  = mm2s_tdata;
    @(negedge clk);
    cycle++;
  endtask

  task automatic clr();
    s2mm_n = 0; mm2s_n = 0; done_n = 0;
    s2mm_cyc.delete();
  endtask

  task automatic start_job(input logic [31:0] sa, input logic [31:0] da, input logic [31:0] ln);
    logic [31:0] rem, b, a_s, a_d;
    int k;
    rem = ln; a_s = sa; a_d = da; k = 0;
    while (rem != 0) begin
      b = (rem > CHUNK) ? CHUNK : rem;
      s2mm_q.push_back(exp_cmd(4'(k % 16), a_d, b[22:0]));
      mm2s_q.push_back(exp_cmd(4'(k % 16), a_s, b[22:0]));
      a_s = a_s + b; a_d = a_d + b; rem = rem - b; k++;
    end
    clr();
    saddr = sa; daddr = da; len = ln; start = 1'b1;
    start_cyc = cycle;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_sts(input logic [7:0] b);
    sts_tvalid = 1'b1; sts_tdata = b;
    cyc();
    sts_tvalid = 1'b0; sts_tdata = 8'h00;
  endtask

  task automatic wait_pairs(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && mm2s_n < n; i++) cyc();
    check(tag, mm2s_n, n);
  endtask

  initial begin
    @(negedge clk);
    cyc(); cyc();
    // Reset state (rst still asserted)
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 4'h0);
    check("rst_s2mm_vld", s2mm_tvalid, 1'b0);
    check("rst_mm2s_vld", mm2s_tvalid, 1'b0);
    check("rst_s2mm_data", s2mm_tdata, 72'h0);
    check("rst_mm2s_data", mm2s_tdata, 72'h0);
    check("rst_sts_rdy", sts_tready, 1'b0);
    rst = 1'b0;
    #1 check("sts_rdy", sts_tready, 1'b1);

    // Single chunk
    start_job(32'h1000_0000, 32'h2000_0000, 32'd1024);
    check("single_vld_n1", s2mm_tvalid, 1'b1);
    check("single_ready_low", ready, 1'b0);
    wait_pairs("single_pairs", 1, 50);
    repeat (20) cyc();
    check("single_no_done", done_n, 0);
    send_sts(8'h80);
    check("single_done", done, 1'b1);
    check("single_ready", ready, 1'b1);
    check("single_err", err, 4'h0);
    cyc();
    check("single_done_1cyc", done, 1'b0);
    check("single_s2mm_n", s2mm_n, 1);
    check("single_q", s2mm_q.size() + mm2s_q.size(), 0);

    // Chunking, address advance with wrap, 2-cycle issue cadence
    start_job(32'hFFFF_0000, 32'h8000_0000, 2*CHUNK + 100);
    wait_pairs("chunk_pairs", 3, 50);
    check("chunk_first_cyc", s2mm_cyc[0], start_cyc + 1);
    check("chunk_cadence1", s2mm_cyc[1] - s2mm_cyc[0], 2);
    check("chunk_cadence2", s2mm_cyc[2] - s2mm_cyc[1], 2);
    send_sts(8'h80); send_sts(8'h81);
    check("chunk_not_done", done, 1'b0);
    send_sts(8'h82);
    check("chunk_done", done, 1'b1);
    check("chunk_err", err, 4'h0);
    check("chunk_q", s2mm_q.size() + mm2s_q.size(), 0);
    cyc();

    // Throttle at MAX_OUT and tag wrap over 20 chunks
    start_job(32'h0100_0000, 32'h0200_0000, 20*CHUNK);
    wait_pairs("thr_pairs", 4, 50);
    repeat (10) cyc();
    check("thr_stall_n", s2mm_n, 4);
    check("thr_stall_vld", s2mm_tvalid, 1'b0);
    for (int k = 0; k < 20; k++) begin
      send_sts(8'h80 | 8'(k % 16));
      repeat (4) cyc();
      check("thr_release", s2mm_n, (k + 5 > 20) ? 20 : k + 5);
    end
    check("thr_done_n", done_n, 1);
    check("thr_err", err, 4'h0);
    check("thr_q", s2mm_q.size() + mm2s_q.size(), 0);

    // Random command backpressure
    start_job(32'h0300_0000, 32'h0400_0000, 3*CHUNK + 7);
    for (int i = 0; i < 400 && mm2s_n < 4; i++) begin
      s2mm_tready = 1'($urandom % 2);
      mm2s_tready = 1'($urandom % 2);
      cyc();
    end
    s2mm_tready = 1'b1; mm2s_tready = 1'b1;
    check("bp_mm2s_n", mm2s_n, 4);
    check("bp_s2mm_n", s2mm_n, 4);
    for (int k = 0; k < 4; k++) send_sts(8'h80 | 8'(k));
    check("bp_done", done, 1'b1);
    check("bp_q", s2mm_q.size() + mm2s_q.size(), 0);
    cyc();

    // SLVERR stops issue, then drains
    start_job(32'h0500_0000, 32'h0600_0000, 8*CHUNK);
    wait_pairs("err_pairs", 4, 50);
    send_sts(8'h80);
    repeat (4) cyc();
    check("err_fifth", s2mm_n, 5);
    send_sts(8'h41);
    check("err_slv", err, 4'h1);
    repeat (6) cyc();
    check("err_no_issue_s2mm", s2mm_n, 5);
    check("err_no_issue_mm2s", mm2s_n, 5);
    check("err_ready_low", ready, 1'b0);
    send_sts(8'h82); send_sts(8'h83);
    check("err_not_done", done, 1'b0);
    send_sts(8'h84);
    check("err_done", done, 1'b1);
    check("err_sticky", err, 4'h1);
    check("err_left", s2mm_q.size(), 3);
    s2mm_q.delete(); mm2s_q.delete();
    cyc();

    // Wrong tag; start clears err
    start_job(32'h0700_0000, 32'h0800_0000, CHUNK);
    check("tag_err_cleared", err, 4'h0);
    wait_pairs("tag_pairs", 1, 50);
    send_sts(8'h85);
    check("tag_err", err, 4'h8);
    check("tag_done", done, 1'b1);
    cyc();

    // Zero length, then stray status in IDLE
    start_job(32'h0900_0000, 32'h0A00_0000, 32'd0);
    check("zero_done", done, 1'b1);
    check("zero_ready", ready, 1'b1);
    check("zero_err", err, 4'h0);
    check("zero_vld", s2mm_tvalid, 1'b0);
    cyc();
    check("zero_done_1cyc", done, 1'b0);
    check("zero_no_cmd", s2mm_n + mm2s_n, 0);
    send_sts(8'h80);
    check("stray_err", err, 4'h8);
    check("stray_ready", ready, 1'b1);

    // Reset during DRAIN, then a clean job
    start_job(32'h0B00_0000, 32'h0C00_0000, 2*CHUNK);
    wait_pairs("rst_pairs", 2, 50);
    send_sts(8'hA0);
    check("drain_dec", err, 4'h2);
    check("drain_busy", ready, 1'b0);
    rst = 1'b1;
    cyc();
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_err", err, 4'h0);
    check("mid_rst_vld", {s2mm_tvalid, mm2s_tvalid}, 2'b00);
    check("mid_rst_data", s2mm_tdata | mm2s_tdata, 72'h0);
    rst = 1'b0;
    s2mm_q.delete(); mm2s_q.delete();
    cyc();
    check("mid_rst_no_done", done_n, 0);
    start_job(32'h0D00_0000, 32'h0E00_0000, 32'd1024);
    wait_pairs("post_rst_pairs", 1, 50);
    send_sts(8'h80);
    check("post_rst_done", done, 1'b1);
    check("post_rst_err", err, 4'h0);
    check("post_rst_q", s2mm_q.size() + mm2s_q.size(), 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
